// File: rtl/test_sequencer.sv
// Runs NUM_TESTS sub-tests one after another through a start/finish handshake. Each test has a
// cycle timeout; per-test verdicts and pass/fail/skip counts are collected for the whole pass.
module test_sequencer #(
   parameter int unsigned NUM_TESTS = 4,
   parameter int unsigned TIMEOUT   = 1024,
   localparam int unsigned IDX_W    = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
   localparam int unsigned CNT_W    = $clog2(NUM_TESTS + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [NUM_TESTS-1:0] enable_i,
   input  logic [NUM_TESTS-1:0] sub_finish_i,
   input  logic [NUM_TESTS-1:0] sub_pass_i,
   output logic [NUM_TESTS-1:0] sub_start_o,
   output logic                 finish_o,
   output logic                 busy_o,
   output logic [IDX_W-1:0]     cur_idx_o,
   output logic [NUM_TESTS-1:0] pass_mask_o,
   output logic [NUM_TESTS-1:0] tmo_mask_o,
   output logic [CNT_W-1:0]     pass_count_o,
   output logic [CNT_W-1:0]     fail_count_o,
   output logic [CNT_W-1:0]     skip_count_o
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT);
   localparam logic [TMR_W-1:0] TmrLast = TMR_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IdxLast = IDX_W'(NUM_TESTS - 1);

   typedef enum logic [2:0] {StIdle, StLaunch, StWait, StNext, StDone} state_e;

   state_e               state_q;
   logic                 start_q;
   logic [TMR_W-1:0]     timer_q;
   logic [IDX_W-1:0]     idx_q;
   logic [NUM_TESTS-1:0] sub_start_q;
   logic                 finish_q;
   logic                 busy_q;
   logic [NUM_TESTS-1:0] pass_mask_q;
   logic [NUM_TESTS-1:0] tmo_mask_q;
   logic [CNT_W-1:0]     pass_count_q;
   logic [CNT_W-1:0]     fail_count_q;
   logic [CNT_W-1:0]     skip_count_q;
   logic                 start_edge;

   assign start_edge = start_i & ~start_q;

   always_ff @(posedge clk_i) begin
      // Edge detector tracks start even through reset, so a held start cannot fire on release.
      start_q <= start_i;
      if (rst_i) begin
         state_q      <= StIdle;
         timer_q      <= '0;
         idx_q        <= '0;
         sub_start_q  <= '0;
         finish_q     <= 1'b0;
         busy_q       <= 1'b0;
         pass_mask_q  <= '0;
         tmo_mask_q   <= '0;
         pass_count_q <= '0;
         fail_count_q <= '0;
         skip_count_q <= '0;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               if (start_edge) begin
                  state_q      <= StLaunch;
                  busy_q       <= 1'b1;
                  finish_q     <= 1'b0;
                  idx_q        <= '0;
                  pass_mask_q  <= '0;
                  tmo_mask_q   <= '0;
                  pass_count_q <= '0;
                  fail_count_q <= '0;
                  skip_count_q <= '0;
               end
            end
            StLaunch: begin
               if (enable_i[idx_q]) begin
                  sub_start_q <= NUM_TESTS'(1) << idx_q;
                  timer_q     <= '0;
                  state_q     <= StWait;
               end else begin
                  skip_count_q <= skip_count_q + CNT_W'(1);
                  state_q      <= StNext;
               end
            end
            StWait: begin
               timer_q <= timer_q + TMR_W'(1);
               // A finish arriving on the last timer cycle still counts as a normal completion.
               if (sub_finish_i[idx_q]) begin
                  if (sub_pass_i[idx_q]) begin
                     pass_mask_q[idx_q] <= 1'b1;
                     pass_count_q       <= pass_count_q + CNT_W'(1);
                  end else begin
                     fail_count_q <= fail_count_q + CNT_W'(1);
                  end
                  sub_start_q <= '0;
                  state_q     <= StNext;
               end else if (timer_q == TmrLast) begin
                  tmo_mask_q[idx_q] <= 1'b1;
                  fail_count_q      <= fail_count_q + CNT_W'(1);
                  sub_start_q       <= '0;
                  state_q           <= StNext;
               end
            end
            StNext: begin
               sub_start_q <= '0;
               if (idx_q == IdxLast) begin
                  finish_q <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= StDone;
               end else begin
                  idx_q   <= idx_q + IDX_W'(1);
                  state_q <= StLaunch;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign sub_start_o  = sub_start_q;
   assign finish_o     = finish_q;
   assign busy_o       = busy_q;
   assign cur_idx_o    = idx_q;
   assign pass_mask_o  = pass_mask_q;
   assign tmo_mask_o   = tmo_mask_q;
   assign pass_count_o = pass_count_q;
   assign fail_count_o = fail_count_q;
   assign skip_count_o = skip_count_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer: per-channel responders answer sub_start after a configured delay,
// and a per-run model predicts verdicts, counts, handshake lengths and total run length.
module tb_test_sequencer;

   localparam int unsigned NT    = 4;
   localparam int unsigned TMO   = 16;
   localparam int          NEVER = 1000;

   logic          clk;
   logic          rst;
   logic          start;
   logic [NT-1:0] enable;
   logic [NT-1:0] sub_finish;
   logic [NT-1:0] sub_pass;
   logic [NT-1:0] sub_start;
   logic          finish;
   logic          busy;
   logic [1:0]    cur_idx;
   logic [NT-1:0] pass_mask;
   logic [NT-1:0] tmo_mask;
   logic [2:0]    pass_count;
   logic [2:0]    fail_count;
   logic [2:0]    skip_count;

   int unsigned   n_checks;
   int unsigned   n_pass;

   // Per-channel response config: finish k cycles after sub_start rises, with verdict v.
   int            cfg_k[NT];
   logic [NT-1:0] cfg_en;
   logic [NT-1:0] cfg_v;

   int            age[NT];
   int            high[NT];
   int            rises[NT];
   logic [NT-1:0] prev_ss;
   int            n_bad_oh;
   int            n_bad_idx;

   test_sequencer #(
      .NUM_TESTS(NT),
      .TIMEOUT  (TMO)
   ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .enable_i    (enable),
      .sub_finish_i(sub_finish),
      .sub_pass_i  (sub_pass),
      .sub_start_o (sub_start),
      .finish_o    (finish),
      .busy_o      (busy),
      .cur_idx_o   (cur_idx),
      .pass_mask_o (pass_mask),
      .tmo_mask_o  (tmo_mask),
      .pass_count_o(pass_count),
      .fail_count_o(fail_count),
      .skip_count_o(skip_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Advance to the next falling edge, observe outputs, then drive the responders.
   task automatic tick();
      logic [NT-1:0] want;
      @(negedge clk);
      for (int i = 0; i < NT; i++) begin
         if (sub_start[i]) begin
            if (!prev_ss[i]) rises[i]++;
            high[i]++;
            age[i]++;
         end else begin
            age[i] = 0;
         end
      end
      if ($countones(sub_start) > 1) n_bad_oh++;
      want = 4'b0001;
      want = want << cur_idx;
      if (sub_start != '0 && sub_start != want) n_bad_idx++;
      prev_ss = sub_start;
      for (int i = 0; i < NT; i++) begin
         if (sub_start[i]) begin
            sub_finish[i] = (age[i] >= cfg_k[i]);
            sub_pass[i]   = cfg_v[i];
         end else begin
            // Inactive channels carry noise that must be ignored.
            sub_finish[i] = 1'($urandom);
            sub_pass[i]   = 1'($urandom);
         end
      end
   endtask

   task automatic set_cfg(input logic [NT-1:0] en, input int k0, input int k1, input int k2,
                          input int k3, input logic [NT-1:0] v);
      cfg_en   = en;
      cfg_k[0] = k0;
      cfg_k[1] = k1;
      cfg_k[2] = k2;
      cfg_k[3] = k3;
      cfg_v    = v;
   endtask

   task automatic run_pass(input bit toggle);
      logic [NT-1:0] e_pass;
      logic [NT-1:0] e_tmo;
      int            e_pc;
      int            e_fc;
      int            e_sc;
      int            e_cyc;
      int            e_high[NT];
      int            cyc;
      int            n_busy_lo;
      e_pass = '0;
      e_tmo  = '0;
      e_pc   = 0;
      e_fc   = 0;
      e_sc   = 0;
      e_cyc  = 0;
      for (int i = 0; i < NT; i++) begin
         if (!cfg_en[i]) begin
            e_sc++;
            e_cyc += 2;
            e_high[i] = 0;
         end else if (cfg_k[i] <= int'(TMO)) begin
            e_cyc += cfg_k[i] + 2;
            e_high[i] = cfg_k[i];
            if (cfg_v[i]) begin
               e_pass[i] = 1'b1;
               e_pc++;
            end else begin
               e_fc++;
            end
         end else begin
            e_cyc += TMO + 2;
            e_high[i] = TMO;
            e_tmo[i] = 1'b1;
            e_fc++;
         end
      end
      for (int i = 0; i < NT; i++) begin
         high[i]  = 0;
         rises[i] = 0;
      end
      n_bad_oh  = 0;
      n_bad_idx = 0;
      n_busy_lo = 0;
      enable    = cfg_en;
      start     = 1'b1;
      tick();
      cyc = 0;
      check_val("finish_clr", finish, 1'b0);
      while (!finish && cyc < e_cyc + 40) begin
         if (!busy) n_busy_lo++;
         start = (toggle && cyc + 3 < e_cyc) ? 1'($urandom) : 1'b0;
         tick();
         cyc++;
      end
      start = 1'b0;
      check_val("run_cycles", cyc, e_cyc);
      check_val("busy_run", n_busy_lo, 0);
      check_val("busy_done", busy, 1'b0);
      check_val("pass_mask", pass_mask, e_pass);
      check_val("tmo_mask", tmo_mask, e_tmo);
      check_val("pass_count", pass_count, e_pc);
      check_val("fail_count", fail_count, e_fc);
      check_val("skip_count", skip_count, e_sc);
      check_val("cur_idx", cur_idx, NT - 1);
      check_val("onehot", n_bad_oh, 0);
      check_val("ss_idx", n_bad_idx, 0);
      for (int i = 0; i < NT; i++) begin
         check_val($sformatf("ss_len%0d", i), high[i], e_high[i]);
         check_val($sformatf("ss_rise%0d", i), rises[i], cfg_en[i] ? 1 : 0);
      end
      repeat (2) tick();
      check_val("finish_hold", {finish, pass_count, fail_count},
                {1'b1, 3'(e_pc), 3'(e_fc)});
   endtask

   initial begin
      n_checks   = 0;
      n_pass     = 0;
      rst        = 1'b1;
      start      = 1'b0;
      enable     = '0;
      sub_finish = '0;
      sub_pass   = '0;
      prev_ss    = '0;
      for (int i = 0; i < NT; i++) begin
         age[i]   = 0;
         high[i]  = 0;
         rises[i] = 0;
      end
      set_cfg(4'b0000, NEVER, NEVER, NEVER, NEVER, 4'b0000);
      repeat (3) tick();
      check_val("rst_outs", {sub_start, finish, busy, cur_idx, pass_mask, tmo_mask,
                             pass_count, fail_count, skip_count}, 0);
      rst = 1'b0;
      tick();
      check_val("idle_outs", {busy, finish, sub_start}, 0);

      // All pass, 3-cycle responders.
      set_cfg(4'b1111, 3, 3, 3, 3, 4'b1111);
      run_pass(1'b0);
      // Test 2 never answers.
      set_cfg(4'b1111, 3, 3, NEVER, 3, 4'b1111);
      run_pass(1'b0);
      // Tests 0 and 2 skipped.
      set_cfg(4'b1010, 3, 3, 3, 3, 4'b1111);
      run_pass(1'b0);
      // Test 1 fails exactly on the last timer cycle; test 3 is one cycle too late.
      set_cfg(4'b1111, 3, TMO, 3, TMO + 1, 4'b1101);
      run_pass(1'b0);

      // Mid-run start toggle is ignored, then reset clears everything.
      set_cfg(4'b1111, 10, 10, 10, 10, 4'b1111);
      enable = cfg_en;
      start  = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check_val("toggle_ign", {busy, cur_idx, sub_start}, {1'b1, 2'd0, 4'b0001});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("rst_mid", {sub_start, finish, busy, cur_idx, pass_mask, tmo_mask,
                            pass_count, fail_count, skip_count}, 0);
      tick();
      check_val("rst_idle", {busy, finish, sub_start}, 0);
      set_cfg(4'b0111, 2, 5, 1, 2, 4'b0101);
      run_pass(1'b0);

      // Back-to-back runs with different verdicts.
      set_cfg(4'b1111, 2, 2, 2, 2, 4'b1111);
      run_pass(1'b0);
      set_cfg(4'b1111, 4, NEVER, 5, 1, 4'b0101);
      run_pass(1'b0);

      // Randomized runs with spurious start toggles while busy.
      repeat (16) begin
         set_cfg(4'($urandom),
                 ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(1, 20)),
                 ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(1, 20)),
                 ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(1, 20)),
                 ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(1, 20)),
                 4'($urandom));
         run_pass(1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
